aes_block_packer: RTL and testbench

- Producer side of the AES block stream: turns a 32-bit word stream from the host/DMA into 128-bit blocks on the aes_in_valid/aes_in_ready/aes_in_block interface consumed by aes256_fifo.
- Zero-pads a short final block and tags it with a last flag and a valid-byte count.
- Holds one assembled block in an output register, so the word stream is not stalled while the AES side is ready.

---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_pack_outreg.sv | 71 +++++++
 rtl/aes_block_packer.sv | 158 +++++++++++++++
 tb/tb_aes_block_packer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared widths, the packer state type and keep-mask helpers for the AES block packer.
package aes_pkg;

    localparam int AES_BLOCK_W         = 128;
    localparam int AES_WORD_W          = 32;
    localparam int AES_WORDS_PER_BLOCK = 4;

    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } pack_state_e;

    function automatic logic [2:0] keep_popcount(input logic [3:0] keep);
        return {2'b00, keep[0]} + {2'b00, keep[1]} + {2'b00, keep[2]} + {2'b00, keep[3]};
    endfunction

    // Legal masks are contiguous from the MSB lane: 8, C, E, F.
    function automatic logic keep_legal(input logic [3:0] keep);
        return (keep == 4'h8) || (keep == 4'hC) || (keep == 4'hE) || (keep == 4'hF);
    endfunction

endpackage

// File: rtl/aes_pack_outreg.sv
// One-block output register: loads a completed block, holds it stable until the consumer
// takes it, and counts transfers. A load in the same cycle as a transfer replaces the block.
module aes_pack_outreg
    import aes_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_i,
    input  logic [AES_BLOCK_W-1:0] blk_i,
    input  logic                   last_i,
    input  logic [4:0]             bytes_i,
    input  logic                   ready_i,
    output logic                   valid_o,
    output logic [AES_BLOCK_W-1:0] blk_o,
    output logic                   last_o,
    output logic [4:0]             bytes_o,
    output logic [CNT_W-1:0]       count_o
);

    logic                   valid_q, valid_d;
    logic [AES_BLOCK_W-1:0] blk_q, blk_d;
    logic                   last_q, last_d;
    logic [4:0]             bytes_q, bytes_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   xfer;

    always_comb begin
        valid_d = valid_q;
        blk_d   = blk_q;
        last_d  = last_q;
        bytes_d = bytes_q;
        count_d = count_q;
        xfer    = valid_q && ready_i;
        if (load_i) begin
            valid_d = 1'b1;
            blk_d   = blk_i;
            last_d  = last_i;
            bytes_d = bytes_i;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
        if (xfer) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            blk_q   <= '0;
            last_q  <= 1'b0;
            bytes_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            blk_q   <= blk_d;
            last_q  <= last_d;
            bytes_q <= bytes_d;
            count_q <= count_d;
        end
    end

    assign valid_o = valid_q;
    assign blk_o   = blk_q;
    assign last_o  = last_q;
    assign bytes_o = bytes_q;
    assign count_o = count_q;

endmodule

// File: rtl/aes_block_packer.sv
// Packs 32-bit words into padded 128-bit AES blocks; block visible one cycle after its last word,
// parks one extra block (in_ready=0) while the output is stalled. AES_PACK_BSWAP_EN: little-endian input.
module aes_block_packer
    import aes_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = 8'h00,
    parameter int         CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_WORD_W-1:0]  in_word,
    input  logic [3:0]             in_keep,
    input  logic                   in_last,
    output logic                   aes_in_valid,
    input  logic                   aes_in_ready,
    output logic [AES_BLOCK_W-1:0] aes_in_block,
    output logic                   blk_last,
    output logic [4:0]             blk_bytes,
    output logic [CNT_W-1:0]       blk_count,
    output logic                   err
);

    pack_state_e            state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic [AES_BLOCK_W-1:0] asm_q, asm_d;
    logic                   pend_last_q, pend_last_d;
    logic [4:0]             pend_bytes_q, pend_bytes_d;
    logic                   err_q, err_d;
    logic                   live_q;

    logic [AES_WORD_W-1:0]  word_eff, word_masked;
    logic [3:0]             keep_eff;
    logic [AES_BLOCK_W-1:0] blk_new;
    logic [4:0]             bytes_new;
    logic                   accept, complete, keep_bad, out_free;
    logic                   load;
    logic [AES_BLOCK_W-1:0] ld_blk;
    logic                   ld_last;
    logic [4:0]             ld_bytes;

`ifdef AES_PACK_BSWAP_EN
    assign word_eff = {in_word[7:0], in_word[15:8], in_word[23:16], in_word[31:24]};
    assign keep_eff = {in_keep[0], in_keep[1], in_keep[2], in_keep[3]};
`else
    assign word_eff = in_word;
    assign keep_eff = in_keep;
`endif

    assign in_ready  = live_q && (state_q == FILL);
    assign accept    = in_valid && in_ready;
    assign complete  = accept && (in_last || (idx_q == 2'(AES_WORDS_PER_BLOCK - 1)));
    assign keep_bad  = !keep_legal(keep_eff) || (!in_last && (keep_eff != 4'hF));
    assign bytes_new = {1'b0, idx_q, 2'b00} + {2'b00, keep_popcount(keep_eff)};
    assign out_free  = !aes_in_valid || aes_in_ready;

    // Lanes before idx keep assembled data, lane idx takes the masked word, later lanes pad.
    // The same image is the assembly next-state, since padded lanes are overwritten later.
    always_comb begin
        word_masked = '0;
        blk_new     = '0;
        for (int b = 0; b < 4; b++) begin
            word_masked[8*b +: 8] = keep_eff[b] ? word_eff[8*b +: 8] : PAD_BYTE;
        end
        for (int j = 0; j < AES_WORDS_PER_BLOCK; j++) begin
            if (2'(j) < idx_q) begin
                blk_new[AES_BLOCK_W-1-AES_WORD_W*j -: AES_WORD_W] =
                    asm_q[AES_BLOCK_W-1-AES_WORD_W*j -: AES_WORD_W];
            end else if (2'(j) == idx_q) begin
                blk_new[AES_BLOCK_W-1-AES_WORD_W*j -: AES_WORD_W] = word_masked;
            end else begin
                blk_new[AES_BLOCK_W-1-AES_WORD_W*j -: AES_WORD_W] = {4{PAD_BYTE}};
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        asm_d        = asm_q;
        pend_last_d  = pend_last_q;
        pend_bytes_d = pend_bytes_q;
        err_d        = err_q;
        load         = 1'b0;
        ld_blk       = blk_new;
        ld_last      = in_last;
        ld_bytes     = bytes_new;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    asm_d = blk_new;
                    idx_d = complete ? 2'd0 : idx_q + 2'd1;
                    err_d = err_q || keep_bad;
                    if (complete) begin
                        if (out_free) begin
                            load = 1'b1;
                        end else begin
                            state_d      = PEND;
                            pend_last_d  = in_last;
                            pend_bytes_d = bytes_new;
                        end
                    end
                end
            end
            PEND: begin
                if (aes_in_valid && aes_in_ready) begin
                    load     = 1'b1;
                    ld_blk   = asm_q;
                    ld_last  = pend_last_q;
                    ld_bytes = pend_bytes_q;
                    state_d  = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FILL;
            idx_q        <= '0;
            asm_q        <= '0;
            pend_last_q  <= 1'b0;
            pend_bytes_q <= '0;
            err_q        <= 1'b0;
            live_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            pend_last_q  <= pend_last_d;
            pend_bytes_q <= pend_bytes_d;
            err_q        <= err_d;
            live_q       <= 1'b1;
        end
    end

    assign err = err_q;

    aes_pack_outreg #(
        .CNT_W (CNT_W)
    ) u_outreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .blk_i   (ld_blk),
        .last_i  (ld_last),
        .bytes_i (ld_bytes),
        .ready_i (aes_in_ready),
        .valid_o (aes_in_valid),
        .blk_o   (aes_in_block),
        .last_o  (blk_last),
        .bytes_o (blk_bytes),
        .count_o (blk_count)
    );

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed and random bench for aes_block_packer against a message-level block model.
module tb_aes_block_packer;

    localparam logic [7:0] PAD = 8'h00;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_last;
    logic [31:0]  in_word;
    logic [3:0]   in_keep;
    logic         aes_in_valid, aes_in_ready;
    logic [127:0] aes_in_block;
    logic         blk_last, err;
    logic [4:0]   blk_bytes;
    logic [31:0]  blk_count;

    aes_block_packer #(.PAD_BYTE(PAD), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_word      (in_word),
        .in_keep      (in_keep),
        .in_last      (in_last),
        .aes_in_valid (aes_in_valid),
        .aes_in_ready (aes_in_ready),
        .aes_in_block (aes_in_block),
        .blk_last     (blk_last),
        .blk_bytes    (blk_bytes),
        .blk_count    (blk_count),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] blk;
        logic         last;
        logic [4:0]   bytes;
        int           cyc;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        obs_q[$];
    logic [31:0] cur_w[$];
    logic [3:0]  cur_k[$];
    logic        exp_err = 1'b0;
    logic [31:0] exp_count = '0;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          rand_done;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && aes_in_valid && aes_in_ready) begin
            obs_q.push_back('{blk: aes_in_block, last: blk_last, bytes: blk_bytes, cyc: cyc});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wire format of a logical (big-endian) word/keep pair.
    function automatic logic [35:0] phys(input logic [31:0] w, input logic [3:0] k);
`ifdef AES_PACK_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24], k[0], k[1], k[2], k[3]};
`else
        return {w, k};
`endif
    endfunction

    // Reference: collect a block's words, then lay out bytes MSB-first and pad the rest.
    task automatic model_word(input logic [31:0] w, input logic [3:0] k, input logic last);
        logic [127:0] blk;
        logic [31:0]  wv;
        logic [3:0]   kv;
        int           n;
        if (!(k inside {4'h8, 4'hC, 4'hE, 4'hF}) || (!last && k != 4'hF)) exp_err = 1'b1;
        cur_w.push_back(w);
        cur_k.push_back(k);
        n = cur_w.size();
        if (last || n == 4) begin
            blk = '0;
            for (int i = 0; i < 4; i++) begin
                wv = (i < n) ? cur_w[i] : 32'h0;
                kv = (i < n) ? cur_k[i] : 4'h0;
                for (int b = 3; b >= 0; b--) begin
                    blk = {blk[119:0], (kv[b] ? wv[8*b +: 8] : PAD)};
                end
            end
            exp_q.push_back('{blk: blk, last: last,
                              bytes: 5'(4 * (n - 1) + $countones(k)), cyc: 0});
            cur_w.delete();
            cur_k.delete();
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic [3:0] k, input logic last);
        int n = 0;
        in_valid = 1'b1;
        {in_word, in_keep} = phys(w, k);
        in_last = last;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_wait", in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_word(w, k, last);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (obs_q.size() < exp_q.size() && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_nblocks"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            rec_t e = exp_q.pop_front();
            rec_t o = obs_q.pop_front();
            chk({tag, "_blk"}, o.blk, e.blk);
            chk({tag, "_last"}, o.last, e.last);
            chk({tag, "_bytes"}, o.bytes, e.bytes);
            exp_count++;
        end
        exp_q.delete();
        obs_q.delete();
        chk({tag, "_count"}, blk_count, exp_count);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        cur_w.delete();
        cur_k.delete();
        exp_q.delete();
        obs_q.delete();
        exp_err = 1'b0;
        exp_count = '0;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_valid", aes_in_valid, 1'b0);
        chk("rst_count", blk_count, exp_count);
        chk("rst_err", err, exp_err);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        logic [127:0] held;
        logic [3:0]   lk;
        int           len;
        logic [3:0]   legal[4] = '{4'h8, 4'hC, 4'hE, 4'hF};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_word = '0;
        in_keep = '0;
        in_last = 1'b0;
        aes_in_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_block", aes_in_block, 128'h0);
        chk("reset_last", blk_last, 1'b0);
        chk("reset_bytes", blk_bytes, 5'd0);
        do_reset();

        // Full block, streamed one word per cycle.
        send_word(32'h00010203, 4'hF, 1'b0);
        send_word(32'h04050607, 4'hF, 1'b0);
        send_word(32'h08090A0B, 4'hF, 1'b0);
        send_word(32'h0C0D0E0F, 4'hF, 1'b1);
        in_valid = 1'b0;
        chk("t1_valid", aes_in_valid, 1'b1);
        chk("t1_block", aes_in_block, 128'h000102030405060708090A0B0C0D0E0F);
        chk("t1_last", blk_last, 1'b1);
        chk("t1_bytes", blk_bytes, 5'd16);
        @(negedge clk);
        chk("t1_count", blk_count, 32'd1);
        drain("t1");

        // Short final block with a partial last word.
        send_word(32'h11223344, 4'hF, 1'b0);
        send_word(32'h5566AABB, 4'hC, 1'b1);
        in_valid = 1'b0;
        chk("t2_block", aes_in_block, 128'h11223344556600000000000000000000);
        chk("t2_bytes", blk_bytes, 5'd6);
        chk("t2_last", blk_last, 1'b1);
        drain("t2");

        // Stalled output: one block held, one parked in assembly.
        aes_in_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_word($urandom, 4'hF, i == 7);
        in_valid = 1'b0;
        held = aes_in_block;
        repeat (3) @(negedge clk);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_valid", aes_in_valid, 1'b1);
        chk("bp_hold", aes_in_block, held);
        chk("bp_first", aes_in_block, exp_q[0].blk);
        chk("bp_count_hold", blk_count, exp_count);
        aes_in_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_nobs", obs_q.size(), 2);
        if (obs_q.size() >= 2) chk("bp_back2back", obs_q[1].cyc - obs_q[0].cyc, 1);
        drain("bp");

        // Random messages with random gaps and random output backpressure.
        rand_done = 1'b0;
        fork
            begin
                for (int m = 0; m < 14; m++) begin
                    len = $urandom_range(1, 9);
                    for (int i = 0; i < len; i++) begin
                        lk = (i == len - 1) ? legal[$urandom_range(0, 3)] : 4'hF;
                        send_word($urandom, lk, i == len - 1);
                        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                    end
                end
                in_valid = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    aes_in_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        aes_in_ready = 1'b1;
        drain("rand");
        chk("rand_err", err, exp_err);

        // Illegal keep on a non-last word: sticky error, data still accepted.
        send_word(32'hA1B2C3D4, 4'h7, 1'b0);
        in_valid = 1'b0;
        chk("err_set", err, 1'b1);
        send_word(32'h01020304, 4'hF, 1'b0);
        send_word(32'h05060708, 4'hF, 1'b0);
        send_word(32'h090A0B0C, 4'hF, 1'b1);
        send_word(32'hDEADBEEF, 4'h8, 1'b1);
        idle(3);
        drain("err");
        chk("err_sticky", err, exp_err);

        // Reset mid-block discards the partial block and clears the error.
        send_word(32'hCAFE0001, 4'hF, 1'b0);
        send_word(32'hCAFE0002, 4'hF, 1'b0);
        do_reset();
        idle(3);
        chk("mid_rst_noblock", obs_q.size(), 0);
        send_word(32'h10111213, 4'hF, 1'b0);
        send_word(32'h14151617, 4'hF, 1'b0);
        send_word(32'h18191A1B, 4'hF, 1'b0);
        send_word(32'h1C1D1E1F, 4'hF, 1'b1);
        in_valid = 1'b0;
        chk("mid_rst_block", aes_in_block, 128'h101112131415161718191A1B1C1D1E1F);
        idle(2);
        drain("mid_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
